serial_code_receiver: RTL and testbench

//  Upstream stage of the 7-segment Display block. Receives one asynchronous serial

---
 rtl/serial_code_receiver_pkg.sv | 15 +
 rtl/serial_code_receiver_if.sv | 15 +
 rtl/serial_code_receiver_rx_sync.sv | 24 ++
 rtl/serial_code_receiver.sv | 132 +++++++++++++
 tb/tb_serial_code_receiver.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_code_receiver_pkg.sv
// Shared definitions for the serial code receiver: frame geometry and FSM state encodings.
package serial_code_receiver_pkg;

  localparam int DATA_BITS        = 5;
  localparam int DEF_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/serial_code_receiver_if.sv
// Serial line in, decoded code/parity and status pulses out toward Display.
interface serial_code_receiver_if;
  import serial_code_receiver_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] E;
  logic                 P;
  logic                 frame_ready;
  logic                 frame_err;
  logic                 busy;

  modport master (output rx, input E, P, frame_ready, frame_err, busy);
  modport slave  (input rx, output E, P, frame_ready, frame_err, busy);

endinterface

// File: rtl/serial_code_receiver_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle level (1).
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/serial_code_receiver.sv
// Receives one start/5-data/parity/stop frame on rx and presents the code and parity to Display.
// States: IDLE wait start | START verify start mid-bit | DATA shift 5 bits | PARITY hold P | STOP check stop bit
module serial_code_receiver
  import serial_code_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_code_receiver_if.slave  bus
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  MID      = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] e_q, e_d;
  logic                 p_q, p_d;
  logic                 rdy_q, rdy_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  rx_sync u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    e_d     = e_q;
    p_d     = p_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == MID) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
            bit_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      // Counter restarts at the start-bit mid point, so LAST lands on each later mid-bit.
      ST_DATA: begin
        if (cnt_q == LAST) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = ST_PARITY;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (cnt_q == LAST) begin
          par_d   = rx_s;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          if (rx_s) begin
            e_d   = shift_q;
            p_d   = par_q;
            rdy_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      e_q     <= '0;
      p_q     <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      e_q     <= e_d;
      p_q     <= p_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.E           = e_q;
  assign bus.P           = p_q;
  assign bus.frame_ready = rdy_q;
  assign bus.frame_err   = err_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_serial_code_receiver.sv
// Directed bench for serial_code_receiver with a 4-clock bit period.
module tb_serial_code_receiver;
  import serial_code_receiver_pkg::*;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_code_receiver_if bus ();

  serial_code_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [5:0] got_q[$];
  int   n_rdy = 0, n_err = 0, n_overlap = 0, n_wide = 0, n_unstable = 0;
  logic prev_rdy = 1'b0, prev_err = 1'b0;
  logic [5:0] prev_ep = 6'd0;

  // Pulse/stability monitor sampled on the inactive edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_ready) begin
        n_rdy++;
        got_q.push_back({bus.P, bus.E});
      end
      if (bus.frame_err) n_err++;
      if (bus.frame_ready && bus.frame_err) n_overlap++;
      if ((bus.frame_ready && prev_rdy) || (bus.frame_err && prev_err)) n_wide++;
      if (({bus.P, bus.E} != prev_ep) && !bus.frame_ready) n_unstable++;
    end
    prev_rdy = bus.frame_ready;
    prev_err = bus.frame_err;
    prev_ep  = {bus.P, bus.E};
  end

  task automatic send_bit(input logic b);
    bus.rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [4:0] e, input logic p, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(e[i]);
    send_bit(p);
    send_bit(stop);
    bus.rx = 1'b1;
  endtask

  task automatic check_frame(input string name, input int rdy0, input int idx,
                             input logic [4:0] exp_e, input logic exp_p, input logic exp_valid);
    total++;
    if (n_rdy - rdy0 !== 1) begin
      bad++; $display("FAIL %s_count: got %0d pulses, want 1", name, n_rdy - rdy0);
    end
    total++;
    if (bus.E !== exp_e) begin
      bad++; $display("FAIL %s_E: got %b, want %b", name, bus.E, exp_e);
    end
    total++;
    if (bus.P !== exp_p) begin
      bad++; $display("FAIL %s_P: got %b, want %b", name, bus.P, exp_p);
    end
    total++;
    if (got_q[idx] !== {exp_p, exp_e}) begin
      bad++; $display("FAIL %s_pulse_data: got %b, want %b", name, got_q[idx], {exp_p, exp_e});
    end
    total++;
    if ((^{bus.E, bus.P}) !== exp_valid) begin
      bad++; $display("FAIL %s_display_valid: got %b, want %b", name, ^{bus.E, bus.P}, exp_valid);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (bus.E !== 5'b00000) begin bad++; $display("FAIL %s_E: got %b, want 00000", name, bus.E); end
    total++;
    if (bus.P !== 1'b0) begin bad++; $display("FAIL %s_P: got %b, want 0", name, bus.P); end
    total++;
    if (bus.frame_ready !== 1'b0) begin bad++; $display("FAIL %s_ready: got %b, want 0", name, bus.frame_ready); end
    total++;
    if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL %s_err: got %b, want 0", name, bus.frame_err); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s_busy: got %b, want 0", name, bus.busy); end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_frame_valid();
    int r0 = n_rdy;
    int i0 = got_q.size();
    send_frame(5'b00001, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check_frame("frame_valid", r0, i0, 5'b00001, 1'b0, 1'b1);
  endtask

  task automatic test_frame_bad_parity();
    int r0 = n_rdy;
    int e0 = n_err;
    int i0 = got_q.size();
    send_frame(5'b00001, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check_frame("frame_parity1", r0, i0, 5'b00001, 1'b1, 1'b0);
    total++;
    if (n_err !== e0) begin bad++; $display("FAIL frame_parity1_err: got %0d, want %0d", n_err, e0); end
  endtask

  task automatic test_glitch();
    int   r0 = n_rdy;
    int   e0 = n_err;
    logic saw_busy = 1'b0;
    bus.rx = 1'b0;
    @(negedge clk);
    bus.rx = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.busy) saw_busy = 1'b1;
    end
    total++;
    if (saw_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_pulse: got %b, want 1", saw_busy); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end: got %b, want 0", bus.busy); end
    total++;
    if ((n_rdy - r0) + (n_err - e0) !== 0) begin
      bad++; $display("FAIL glitch_pulses: got %0d ready %0d err, want 0 0", n_rdy - r0, n_err - e0);
    end
    total++;
    if ({bus.P, bus.E} !== 6'b100001) begin bad++; $display("FAIL glitch_hold: got %b, want 100001", {bus.P, bus.E}); end
  endtask

  task automatic test_stop_error();
    int r0 = n_rdy;
    int e0 = n_err;
    send_frame(5'b10101, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    total++;
    if (n_err - e0 !== 1) begin bad++; $display("FAIL stop_err_count: got %0d, want 1", n_err - e0); end
    total++;
    if (n_rdy !== r0) begin bad++; $display("FAIL stop_err_ready: got %0d, want 0", n_rdy - r0); end
    total++;
    if ({bus.P, bus.E} !== 6'b100001) begin bad++; $display("FAIL stop_err_hold: got %b, want 100001", {bus.P, bus.E}); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL stop_err_idle: got %b, want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int r0 = n_rdy;
    int i0 = got_q.size();
    send_frame(5'b00010, 1'b0, 1'b1);
    send_frame(5'b10101, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if (n_rdy - r0 !== 2) begin bad++; $display("FAIL b2b_count: got %0d, want 2", n_rdy - r0); end
    total++;
    if (got_q[i0] !== 6'b000010) begin bad++; $display("FAIL b2b_first: got %b, want 000010", got_q[i0]); end
    total++;
    if (got_q[i0+1] !== 6'b010101) begin bad++; $display("FAIL b2b_second: got %b, want 010101", got_q[i0+1]); end
    total++;
    if ({bus.P, bus.E} !== 6'b010101) begin bad++; $display("FAIL b2b_final: got %b, want 010101", {bus.P, bus.E}); end
  endtask

  task automatic test_reset_mid_frame();
    int r0;
    int i0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b, want 1", bus.busy); end
    #1;
    rst    = 1'b1;
    bus.rx = 1'b1;
    #1;
    check_reset_outputs("midrst_immediate");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    r0 = n_rdy;
    i0 = got_q.size();
    send_frame(5'b01101, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check_frame("midrst_next_frame", r0, i0, 5'b01101, 1'b1, 1'b0);
  endtask

  task automatic test_invariants();
    total++;
    if (n_overlap !== 0) begin bad++; $display("FAIL inv_overlap: got %0d cycles, want 0", n_overlap); end
    total++;
    if (n_wide !== 0) begin bad++; $display("FAIL inv_pulse_width: got %0d wide cycles, want 0", n_wide); end
    total++;
    if (n_unstable !== 0) begin bad++; $display("FAIL inv_ep_stable: got %0d changes, want 0", n_unstable); end
  endtask

  initial begin
    rst    = 1'b1;
    bus.rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_frame_valid();
    test_frame_bad_parity();
    test_glitch();
    test_stop_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
